// File: rtl/plab4_net_mux_arb_if.sv
// Handshake bundle for the two-domain merge stage: two val/rdy input streams
// and one shared val/rdy output channel carrying a domain tag.
interface plab4_net_mux_arb_if #(
    parameter int unsigned p_msg_cnbits = 32,
    parameter int unsigned p_msg_dnbits = 32
);
    logic                    in_val_d1;
    logic                    in_rdy_d1;
    logic [p_msg_cnbits-1:0] in_msg_control_d1;
    logic [p_msg_dnbits-1:0] in_msg_data_d1;

    logic                    in_val_d2;
    logic                    in_rdy_d2;
    logic [p_msg_cnbits-1:0] in_msg_control_d2;
    logic [p_msg_dnbits-1:0] in_msg_data_d2;

    logic                    out_val;
    logic                    out_rdy;
    logic                    out_domain;
    logic [p_msg_cnbits-1:0] out_msg_control;
    logic [p_msg_dnbits-1:0] out_msg_data;

    // Upstream producers and downstream consumer
    modport master (
        output in_val_d1, in_msg_control_d1, in_msg_data_d1,
        output in_val_d2, in_msg_control_d2, in_msg_data_d2,
        output out_rdy,
        input  in_rdy_d1, in_rdy_d2,
        input  out_val, out_domain, out_msg_control, out_msg_data
    );

    // The merge stage itself
    modport slave (
        input  in_val_d1, in_msg_control_d1, in_msg_data_d1,
        input  in_val_d2, in_msg_control_d2, in_msg_data_d2,
        input  out_rdy,
        output in_rdy_d1, in_rdy_d2,
        output out_val, out_domain, out_msg_control, out_msg_data
    );
endinterface

// File: rtl/plab4_net_mux_arb.sv
// Round-robin merge of domain D1/D2 message streams into a single-entry
// registered output buffer; empty buffer contents are held at zero.
module plab4_net_mux_arb #(
    parameter int unsigned p_msg_cnbits = 32,
    parameter int unsigned p_msg_dnbits = 32
) (
    input logic              clk,
    input logic              reset,
    plab4_net_mux_arb_if.slave bus
);

    logic                    full_q;
    logic                    last_q;
    logic                    buf_domain_q;
    logic [p_msg_cnbits-1:0] buf_control_q;
    logic [p_msg_dnbits-1:0] buf_data_q;

    logic gnt_val;
    logic gnt_dom;
    logic space;
    logic enq;

    // Grant depends only on valids and last, never on message fields
    always_comb begin
        gnt_val = bus.in_val_d1 || bus.in_val_d2;
        gnt_dom = (bus.in_val_d1 && bus.in_val_d2) ? !last_q : bus.in_val_d2;
        space   = !full_q || bus.out_rdy;
        enq     = gnt_val && space;
    end

    assign bus.in_rdy_d1 = enq && !gnt_dom;
    assign bus.in_rdy_d2 = enq && gnt_dom;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            full_q        <= 1'b0;
            last_q        <= 1'b1;
            buf_domain_q  <= 1'b0;
            buf_control_q <= '0;
            buf_data_q    <= '0;
        end else if (enq) begin
            full_q        <= 1'b1;
            last_q        <= gnt_dom;
            buf_domain_q  <= gnt_dom;
            buf_control_q <= gnt_dom ? bus.in_msg_control_d2 : bus.in_msg_control_d1;
            buf_data_q    <= gnt_dom ? bus.in_msg_data_d2 : bus.in_msg_data_d1;
        end else if (full_q && bus.out_rdy) begin
            // Drain with nothing behind it: scrub so no stale payload leaks
            full_q        <= 1'b0;
            buf_domain_q  <= 1'b0;
            buf_control_q <= '0;
            buf_data_q    <= '0;
        end
    end

    assign bus.out_val         = full_q;
    assign bus.out_domain      = buf_domain_q;
    assign bus.out_msg_control = buf_control_q;
    assign bus.out_msg_data    = buf_data_q;

endmodule

// File: doc/plab4_net_mux_arb.md
# plab4_net_mux_arb

Two-domain merge stage: the inverse of the domain demux. Accepts val/rdy message streams from domain D1 and domain D2 and arbitrates them round-robin onto one shared output channel. Each message carries a 1-bit domain tag identifying its source. A single-entry registered output buffer decouples the two sides. The block sits where per-domain request/response paths re-converge onto a shared network port. Empty-buffer contents are scrubbed to zero so no stale payload from one domain is visible while the other domain owns the channel.

## Interface
Parameters:
- p_msg_cnbits, 32, control field width
- p_msg_dnbits, 32, data field width

Ports:
- clk  input  1  clock; all state updates on rising edge
- reset  input  1  asynchronous, active-low; clears all state immediately when low
- in_val_d1  input  1  D1 message valid
- in_rdy_d1  output  1  D1 message accepted this cycle when high together with in_val_d1
- in_msg_control_d1  input  p_msg_cnbits  D1 control field
- in_msg_data_d1  input  p_msg_dnbits  D1 data field
- in_val_d2 / in_rdy_d2 / in_msg_control_d2 / in_msg_data_d2: same as the D1 ports, for D2
- out_val  output  1  output buffer holds a message
- out_rdy  input  1  downstream accepts when high together with out_val
- out_domain  output  1  source of the buffered message: 0 = D1, 1 = D2
- out_msg_control  output  p_msg_cnbits  buffered control field
- out_msg_data  output  p_msg_dnbits  buffered data field

## Operation
- State: full (1b), buf_domain (1b), buf_control, buf_data, last (1b, domain granted most recently).
- space = !full || out_rdy. The buffer can accept in the same cycle it drains.
- Grant (combinational):
  - Only D1 valid -> D1.
  - Only D2 valid -> D2.
  - Both valid -> the domain != last.
  - Neither valid -> none.
- in_rdy_dX = grant==X && space. The non-granted domain's rdy is 0. in_rdy never depends on the non-granted domain's message fields.
- Enqueue (grant valid && space): on the clock edge, load the granted domain's control/data, set buf_domain to the granted domain, set full=1, set last to the granted domain.
- Dequeue without enqueue (full && out_rdy && no grant): full=0. buf_control, buf_data and buf_domain clear to 0.
- Simultaneous dequeue and enqueue: the new message replaces the old one; full stays 1.
- Outputs are driven directly from registers: out_val=full, plus out_domain, out_msg_control, out_msg_data. When full=0, all of these are 0.
- Backpressure: while full && !out_rdy, the buffer holds its contents stable, both in_rdy are 0, and last does not change.
- Reset low: full=0, last=1 (D1 wins the first tie), all buffer fields 0. This takes effect asynchronously, including mid-transfer. Any message in the buffer is dropped. Reset has priority over any same-edge handshake.

## Timing
- Latency: 1 cycle. A message accepted at edge N is visible on out_* after edge N.
- Throughput: 1 message/cycle while out_rdy=1.
- Both domains continuously valid with out_rdy=1: grants alternate D1, D2, D1, … every cycle.
- in_rdy_d1/in_rdy_d2 are combinational from in_val_*, full, out_rdy and last. There is no combinational path from in_msg_* to any output.
- Upstream must hold in_val and the message fields stable until accepted. The block does not require this for correctness; it samples only on the accept edge.
- After reset deasserts, the first accept is possible on the first rising edge.

## Test plan
- Reset/idle: hold reset low, then release with no valids. Required: out_val=0, out_domain=0, out_msg_*=0, in_rdy_d1=in_rdy_d2=0 after release.
- Single D2 transfer: in_val_d2=1, control=0x0000_00A5, data=0xDEAD_BEEF, out_rdy=1. Required:
  - in_rdy_d2=1 in the accept cycle.
  - Next cycle: out_val=1, out_domain=1, fields match.
  - The cycle after, with no new input: all out_* return to 0.
- Fair arbitration: both domains valid continuously with distinct payloads (D1: 0x1, 0x2, …; D2: 0x100, 0x200, …), out_rdy=1. Required: output order 0x1, 0x100, 0x2, 0x200, …, with out_domain alternating 0, 1, 0, 1.
- Backpressure: fill the buffer with D1 message 0x11, then hold out_rdy=0 for 5 cycles with D2 valid. Required:
  - out_* stay fixed at 0x11/domain 0.
  - in_rdy_d2=0 throughout.
  - Raising out_rdy drains 0x11 and accepts D2 in the same cycle; D2 appears on the next cycle.
- Async reset mid-operation: buffer full with D2 message 0x55 and out_rdy=0; pull reset low between clock edges. Required: out_val, out_domain and out_msg_* drop to 0 before the next edge. After release with both valid, D1 is granted first.
- Isolation: D1 valid with data 0xCAFE, D2 idle, out_rdy toggling randomly for 200 cycles. Required:
  - Every D1 message is delivered exactly once, in order.
  - out_domain=0 whenever out_val=1.
  - out_msg_data=0 whenever out_val=0.
